rect_layer_ctrl: RTL and testbench
==================================

Name: rect_layer_ctrl

Overview:
- Holds a bank of rectangle descriptors and draws them over the pixel_itr raster, producing 1-bit r/g/b plus aligned syncs.
- Replaces hard-coded window comparators in screen_design.
- A host loads descriptors into a shadow bank through a valid/ready write port, then requests a commit.
- The shadow bank is copied to the active bank only at the frame boundary, so a frame never shows half-updated shapes.
- Overlapping rectangles are resolved by fixed priority.

Parameters:
- N_RECT, 4, number of rectangle slots (index width IDX_W = clog2(N_RECT), minimum 1)
- COORD_W, 12, coordinate width; matches pix_x/pix_y
- H_ACTIVE, 800, visible pixels per line
- V_ACTIVE, 600, visible lines per frame

Ports:
- clk  in  1  system clock; same clock as pixel_itr
- rst  in  1  synchronous reset, active-low: sampled on the rising clk edge, state cleared while rst==0
- pix_x  in  COORD_W  current pixel column from pixel_itr
- pix_y  in  COORD_W  current pixel row from pixel_itr
- h_sync_in  in  1  h_sync from pixel_itr
- v_sync_in  in  1  v_sync from pixel_itr
- wr_valid  in  1  host write request
- wr_ready  out  1  controller accepts write
- wr_idx  in  IDX_W  target slot
- wr_field  in  3  0=x0, 1=y0, 2=x1, 3=y1, 4=attr (wr_data[2:0]=rgb, wr_data[3]=enable)
- wr_data  in  COORD_W  field value
- commit  in  1  request shadow→active swap
- commit_done  out  1  one-cycle pulse when the swap is performed
- busy  out  1  high while a commit is pending
- h_sync  out  1  h_sync_in delayed 1 cycle
- v_sync  out  1  v_sync_in delayed 1 cycle
- r_out, g_out, b_out  out  1 each  pixel colour, aligned with h_sync/v_sync
- hit_valid  out  1  some rectangle covers the current output pixel
- hit_idx  out  IDX_W  winning slot; 0 when hit_valid==0

Behaviour:
- Reset (rst==0 at an edge):
  - Shadow and active banks cleared: all fields 0, enable=0.
  - FSM goes to IDLE.
  - All outputs 0; wr_ready becomes 1 on the first cycle after reset releases.
- Write handshake:
  - A write occurs on any cycle with wr_valid && wr_ready.
  - It updates shadow[wr_idx].field with wr_data.
  - Attr writes take wr_data[3:0]; upper bits are ignored.
  - wr_field 5..7 and wr_idx >= N_RECT are accepted and have no effect.
- Frame boundary (fb): single-cycle condition pix_x==0 && pix_y==V_ACTIVE, i.e. the first pixel of the first blanking line.
- FSM:
  - IDLE: wr_ready=1, busy=0. commit=1 → PENDING. A write in the same cycle as commit is applied and included in that commit.
  - PENDING: wr_ready=0, busy=1; commit is ignored. On fb → SWAP.
  - SWAP (exactly 1 cycle): active ← shadow for all slots; commit_done=1; wr_ready=0; busy=1. Next state IDLE.
  - Shadow contents persist after a swap, so incremental edits are possible.
- Commit and fb in the same IDLE cycle: go to PENDING; the swap waits for the next fb, one frame later. This is deterministic; there is no same-cycle swap.
- Reset during PENDING or SWAP: both banks cleared, FSM to IDLE, no commit_done pulse.
- Pixel path, 1-cycle registered latency:
  - Slot i hits when active[i].enable && x0<=pix_x<x1 && y0<=pix_y<y1. The comparison is unsigned and half-open.
  - x0>=x1 or y0>=y1 gives an empty rectangle, never a hit.
  - Visible area: pix_x<H_ACTIVE && pix_y<V_ACTIVE; outside it, no hit.
  - Priority: the lowest index that hits wins.
  - Registered outputs:
    - hit_valid, hit_idx
    - {r_out,g_out,b_out} = winning rgb, or 000 if no hit
    - h_sync/v_sync = previous-cycle inputs, so colour and syncs stay aligned
- The active bank is read only by the pixel path. The SWAP write lands at fb, which is in blanking, so no visible pixel uses a mixed bank.

Test Plan:
- After reset: shadow slot0 = x0=240,y0=0,x1=1000,y1=599, attr=0x9 (enable, rgb=001=red); commit.
  - busy stays 1 until pix_y==600,pix_x==0; commit_done pulses the next cycle.
  - In the following frame, pixel (300,10) gives r_out=1 one cycle after presentation; (239,10), (800,10) and (300,599) give 0.
- Overlap: slot1 = (255,40)-(305,90) green (attr 0xA); slot0 as above.
  - Pixel (260,50) gives hit_idx=0, red.
  - Disable slot0 and commit; the same pixel gives hit_idx=1, g_out=1 only.
- Write during PENDING: wr_valid held → wr_ready=0 until SWAP ends; the write is accepted in IDLE and does not appear until the next commit.
- commit asserted on the fb cycle → no swap at that fb; commit_done appears exactly one frame later.
- rst=0 while PENDING → no commit_done; outputs 0 at the next frame; wr_ready=1 the cycle after release.
- Degenerate inputs: x0=x1=500 gives no hit; wr_field=6 and wr_idx=N_RECT writes are accepted with banks unchanged; h_sync/v_sync are delayed exactly 1 cycle.

Source files
------------

// File: rtl/rect_layer_ctrl.sv
// rect_layer_ctrl: bank of rectangle descriptors drawn over the pixel_itr
// raster. The host fills a shadow bank; a commit copies it to the active bank
// at the next frame boundary. Lowest-index hit wins; outputs registered 1 cycle.
module rect_layer_ctrl #(
  parameter int unsigned N_RECT   = 4,
  parameter int unsigned COORD_W  = 12,
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned V_ACTIVE = 600,
  localparam int unsigned IDX_W   = (N_RECT > 1) ? $clog2(N_RECT) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  input  logic               h_sync_in,
  input  logic               v_sync_in,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [2:0]         wr_field,
  input  logic [COORD_W-1:0] wr_data,
  input  logic               commit,
  output logic               commit_done,
  output logic               busy,
  output logic               h_sync,
  output logic               v_sync,
  output logic               r_out,
  output logic               g_out,
  output logic               b_out,
  output logic               hit_valid,
  output logic [IDX_W-1:0]   hit_idx
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PENDING,
    ST_SWAP
  } state_e;

  typedef struct packed {
    logic [COORD_W-1:0] x0;
    logic [COORD_W-1:0] y0;
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y1;
    logic [2:0]         rgb;   // rgb[0]=red, rgb[1]=green, rgb[2]=blue
    logic               en;
  } rect_t;

  state_e             state_q, state_d;
  rect_t              shadow_q [N_RECT];
  rect_t              shadow_d [N_RECT];
  rect_t              active_q [N_RECT];
  rect_t              active_d [N_RECT];
  logic               up_q, up_d;
  logic               hit_valid_q, hit_valid_d;
  logic [IDX_W-1:0]   hit_idx_q, hit_idx_d;
  logic [2:0]         rgb_q, rgb_d;
  logic               h_sync_q, h_sync_d;
  logic               v_sync_q, v_sync_d;
  logic               fb;

  // First pixel of the first blanking line
  assign fb = (pix_x == '0) && (pix_y == COORD_W'(V_ACTIVE));

  // State, banks and pixel-path registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      up_q        <= 1'b0;
      for (int unsigned i = 0; i < N_RECT; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      hit_valid_q <= 1'b0;
      hit_idx_q   <= '0;
      rgb_q       <= '0;
      h_sync_q    <= 1'b0;
      v_sync_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      up_q        <= up_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      hit_valid_q <= hit_valid_d;
      hit_idx_q   <= hit_idx_d;
      rgb_q       <= rgb_d;
      h_sync_q    <= h_sync_d;
      v_sync_q    <= v_sync_d;
    end
  end

  // Commit sequencing: a commit waits for the next frame boundary, then swaps
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (commit) state_d = ST_PENDING;
      ST_PENDING: if (fb)     state_d = ST_SWAP;
      ST_SWAP:                state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // Handshake and status outputs; writes are held off for the first cycle after reset
  always_comb begin
    wr_ready    = 1'b0;
    busy        = 1'b0;
    commit_done = 1'b0;
    unique case (state_q)
      ST_IDLE:    wr_ready = up_q;
      ST_PENDING: busy = 1'b1;
      ST_SWAP: begin
        busy        = 1'b1;
        commit_done = 1'b1;
      end
      default: ;
    endcase
  end

  // Shadow writes from the host, active bank loaded wholesale in SWAP
  always_comb begin
    up_d     = 1'b1;
    shadow_d = shadow_q;
    active_d = active_q;
    if (wr_valid && wr_ready) begin
      for (int unsigned i = 0; i < N_RECT; i++) begin
        if (wr_idx == IDX_W'(i)) begin
          unique case (wr_field)
            3'd0: shadow_d[i].x0 = wr_data;
            3'd1: shadow_d[i].y0 = wr_data;
            3'd2: shadow_d[i].x1 = wr_data;
            3'd3: shadow_d[i].y1 = wr_data;
            3'd4: begin
              shadow_d[i].rgb = wr_data[2:0];
              shadow_d[i].en  = wr_data[3];
            end
            default: ;
          endcase
        end
      end
    end
    if (state_q == ST_SWAP) active_d = shadow_q;
  end

  // Hit test against the active bank; lowest index wins, syncs delayed to match
  always_comb begin
    logic vis;
    logic slot_hit;
    hit_valid_d = 1'b0;
    hit_idx_d   = '0;
    rgb_d       = '0;
    h_sync_d    = h_sync_in;
    v_sync_d    = v_sync_in;
    vis = (pix_x < COORD_W'(H_ACTIVE)) && (pix_y < COORD_W'(V_ACTIVE));
    for (int unsigned i = 0; i < N_RECT; i++) begin
      slot_hit = vis && active_q[i].en &&
                 (pix_x >= active_q[i].x0) && (pix_x < active_q[i].x1) &&
                 (pix_y >= active_q[i].y0) && (pix_y < active_q[i].y1);
      if (slot_hit && !hit_valid_d) begin
        hit_valid_d = 1'b1;
        hit_idx_d   = IDX_W'(i);
        rgb_d       = active_q[i].rgb;
      end
    end
  end

  assign hit_valid = hit_valid_q;
  assign hit_idx   = hit_idx_q;
  assign r_out     = rgb_q[0];
  assign g_out     = rgb_q[1];
  assign b_out     = rgb_q[2];
  assign h_sync    = h_sync_q;
  assign v_sync    = v_sync_q;

endmodule

// File: tb/tb_rect_layer_ctrl.sv
// tb_rect_layer_ctrl: directed scenarios plus randomized traffic, every cycle
// compared against a behavioural model of the shadow/active banks.
module tb_rect_layer_ctrl;
  localparam int unsigned N  = 3;   // 3 slots so wr_idx==N is expressible
  localparam int unsigned CW = 12;
  localparam int unsigned HA = 800;
  localparam int unsigned VA = 600;
  localparam int unsigned IW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [CW-1:0] pix_x = '0, pix_y = '0;
  logic          h_sync_in = 1'b0, v_sync_in = 1'b0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [IW-1:0] wr_idx = '0;
  logic [2:0]    wr_field = '0;
  logic [CW-1:0] wr_data = '0;
  logic          commit = 1'b0;
  logic          commit_done, busy, h_sync, v_sync, r_out, g_out, b_out, hit_valid;
  logic [IW-1:0] hit_idx;

  always #5 clk = ~clk;

  rect_layer_ctrl #(.N_RECT(N), .COORD_W(CW), .H_ACTIVE(HA), .V_ACTIVE(VA)) dut (
    .clk(clk), .rst(rst), .pix_x(pix_x), .pix_y(pix_y),
    .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_idx(wr_idx),
    .wr_field(wr_field), .wr_data(wr_data), .commit(commit),
    .commit_done(commit_done), .busy(busy), .h_sync(h_sync), .v_sync(v_sync),
    .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .hit_valid(hit_valid), .hit_idx(hit_idx)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: banks as plain integer arrays, commit tracked as pending/swapping flags
  int sx0[N], sy0[N], sx1[N], sy1[N], sat[N];
  int ax0[N], ay0[N], ax1[N], ay1[N], aat[N];
  bit m_init = 0, m_up = 0, m_pend = 0, m_swap = 0, m_acc = 0;
  int e_hv = 0, e_hi = 0, e_r = 0, e_g = 0, e_b = 0, e_hs = 0, e_vs = 0;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic ref_pixel(input int x, input int y);
    e_hv = 0; e_hi = 0; e_r = 0; e_g = 0; e_b = 0;
    if (x < HA && y < VA) begin
      for (int i = 0; i < N; i++) begin
        if (e_hv == 0 && ((aat[i] >> 3) & 1) == 1 &&
            x >= ax0[i] && x < ax1[i] && y >= ay0[i] && y < ay1[i]) begin
          e_hv = 1; e_hi = i;
          e_r = aat[i] & 1; e_g = (aat[i] >> 1) & 1; e_b = (aat[i] >> 2) & 1;
        end
      end
    end
  endtask

  task automatic model_edge();
    bit ready, fb;
    int x, y, idx;
    x = int'(pix_x); y = int'(pix_y); idx = int'(wr_idx);
    if (rst !== 1'b1) begin
      for (int i = 0; i < N; i++) begin
        sx0[i] = 0; sy0[i] = 0; sx1[i] = 0; sy1[i] = 0; sat[i] = 0;
        ax0[i] = 0; ay0[i] = 0; ax1[i] = 0; ay1[i] = 0; aat[i] = 0;
      end
      m_init = 1; m_up = 0; m_pend = 0; m_swap = 0; m_acc = 0;
      e_hv = 0; e_hi = 0; e_r = 0; e_g = 0; e_b = 0; e_hs = 0; e_vs = 0;
      return;
    end
    ready = m_up && !m_pend && !m_swap;
    fb    = (x == 0 && y == VA);
    ref_pixel(x, y);
    e_hs  = int'(h_sync_in);
    e_vs  = int'(v_sync_in);
    m_acc = wr_valid && ready;
    if (m_acc && idx < N) begin
      case (int'(wr_field))
        0: sx0[idx] = int'(wr_data);
        1: sy0[idx] = int'(wr_data);
        2: sx1[idx] = int'(wr_data);
        3: sy1[idx] = int'(wr_data);
        4: sat[idx] = int'(wr_data) & 15;
        default: ;
      endcase
    end
    if (m_swap) begin
      ax0 = sx0; ay0 = sy0; ax1 = sx1; ay1 = sy1; aat = sat;
      m_swap = 0;
    end else if (m_pend) begin
      if (fb) begin m_pend = 0; m_swap = 1; end
    end else if (commit) begin
      m_pend = 1;
    end
    m_up = 1;
  endtask

  // One clock: status checked before the edge, pixel outputs #1 after it
  task automatic step();
    if (m_init) begin
      check_eq("wr_ready", int'(wr_ready), int'(m_up && !m_pend && !m_swap));
      check_eq("busy", int'(busy), int'(m_pend || m_swap));
      check_eq("commit_done", int'(commit_done), int'(m_swap));
    end
    model_edge();
    @(posedge clk);
    #1;
    if (m_init) begin
      check_eq("hit_valid", int'(hit_valid), e_hv);
      check_eq("hit_idx", int'(hit_idx), e_hi);
      check_eq("r_out", int'(r_out), e_r);
      check_eq("g_out", int'(g_out), e_g);
      check_eq("b_out", int'(b_out), e_b);
      check_eq("h_sync", int'(h_sync), e_hs);
      check_eq("v_sync", int'(v_sync), e_vs);
    end
  endtask

  task automatic set_pix(input int x, input int y);
    pix_x = CW'(x);
    pix_y = CW'(y);
  endtask

  // Holds wr_valid until the model accepts; optional frame boundary at iteration fb_at
  task automatic do_write(input int idx, input int fld, input int data, input int fb_at = -1);
    int n;
    n = 0;
    wr_valid = 1'b1; wr_idx = IW'(idx); wr_field = 3'(fld); wr_data = CW'(data);
    m_acc = 0;
    while (!m_acc && n < 40) begin
      if (n == fb_at) set_pix(0, VA); else set_pix(1, 1);
      step();
      n++;
    end
    wr_valid = 1'b0;
    check_eq("write_accepted", int'(m_acc), 1);
  endtask

  task automatic do_commit();
    commit = 1'b1; set_pix(1, 1); step(); commit = 1'b0;
  endtask

  task automatic do_fb();
    set_pix(0, VA); step();
    set_pix(1, 1);  step();
  endtask

  task automatic pix_at(input int x, input int y);
    set_pix(x, y); step();
  endtask

  task automatic write_rect(input int idx, input int x0, input int y0,
                            input int x1, input int y1, input int attr);
    do_write(idx, 0, x0); do_write(idx, 1, y0);
    do_write(idx, 2, x1); do_write(idx, 3, y1);
    do_write(idx, 4, attr);
  endtask

  initial begin
    repeat (3) step();
    rst = 1'b1;
    step();
    check_eq("ready_after_rst", int'(wr_ready), 1);

    // Single red rectangle, commit waits for the frame boundary
    write_rect(0, 240, 0, 1000, 599, 'h9);
    do_commit();
    set_pix(5, VA);  step(); check_eq("busy_wait_a", int'(busy), 1);
    set_pix(0, 599); step(); check_eq("busy_wait_b", int'(busy), 1);
    set_pix(0, VA);  step(); check_eq("done_pulse", int'(commit_done), 1);
    set_pix(1, 1);   step(); check_eq("done_clear", int'(commit_done), 0);
    check_eq("busy_clear", int'(busy), 0);
    pix_at(300, 10); check_eq("red_in", int'(r_out), 1);
    pix_at(239, 10); check_eq("left_edge", int'(r_out), 0);
    pix_at(800, 10); check_eq("not_visible", int'(r_out), 0);
    pix_at(300, 599); check_eq("bottom_edge", int'(r_out), 0);

    // Overlap: slot0 wins until it is disabled
    write_rect(1, 255, 40, 305, 90, 'hA);
    do_commit(); do_fb();
    pix_at(260, 50);
    check_eq("ovl_idx0", int'(hit_idx), 0); check_eq("ovl_red", int'(r_out), 1);
    check_eq("ovl_no_green", int'(g_out), 0);
    do_write(0, 4, 'h1);
    do_commit(); do_fb();
    pix_at(260, 50);
    check_eq("ovl_idx1", int'(hit_idx), 1); check_eq("ovl_green", int'(g_out), 1);
    check_eq("ovl_red_off", int'(r_out), 0);

    // Write held through PENDING/SWAP, visible only after a later commit
    write_rect(2, 600, 400, 700, 500, 'h4);
    do_commit();
    do_write(2, 4, 'hC, 3);
    pix_at(650, 450); check_eq("late_write_hidden", int'(hit_valid), 0);
    do_commit(); do_fb();
    pix_at(650, 450);
    check_eq("late_write_shown", int'(hit_idx), 2); check_eq("blue", int'(b_out), 1);

    // Commit on the boundary cycle waits a full frame
    commit = 1'b1; set_pix(0, VA); step(); commit = 1'b0;
    set_pix(1, 1); step();
    check_eq("fb_commit_no_swap", int'(commit_done), 0);
    check_eq("fb_commit_busy", int'(busy), 1);
    repeat (3) step();
    set_pix(0, VA); step(); check_eq("fb_commit_done", int'(commit_done), 1);
    set_pix(1, 1); step();

    // Reset while pending drops the commit and clears both banks
    do_commit(); step();
    rst = 1'b0; step(); step();
    rst = 1'b1; step();
    check_eq("ready_after_rst2", int'(wr_ready), 1);
    do_fb();
    pix_at(300, 10); check_eq("rst_cleared_hit", int'(hit_valid), 0);
    check_eq("rst_cleared_red", int'(r_out), 0);

    // Degenerate geometry and ignored writes
    write_rect(0, 500, 0, 500, 599, 'h9);
    write_rect(2, 600, 400, 700, 500, 'hC);
    do_commit(); do_fb();
    pix_at(500, 10); check_eq("empty_rect", int'(hit_valid), 0);
    do_write(1, 6, 'hFFF);
    do_write(3, 0, 0);
    do_write(3, 4, 'hF);
    do_commit(); do_fb();
    pix_at(650, 450); check_eq("ignored_writes", int'(hit_idx), 2);
    pix_at(260, 50);  check_eq("ignored_field6", int'(hit_valid), 0);
    h_sync_in = 1'b1; v_sync_in = 1'b0; step();
    check_eq("hs_delay", int'(h_sync), 1); check_eq("vs_delay", int'(v_sync), 0);
    h_sync_in = 1'b0; v_sync_in = 1'b1; step();
    check_eq("hs_delay2", int'(h_sync), 0); check_eq("vs_delay2", int'(v_sync), 1);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 14) == 0) set_pix(0, VA);
      else if ($urandom_range(0, 1) == 0) set_pix($urandom_range(0, 1100), $urandom_range(0, 700));
      else set_pix($urandom_range(0, 400), $urandom_range(0, 200));
      h_sync_in = 1'($urandom_range(0, 1));
      v_sync_in = 1'($urandom_range(0, 1));
      wr_valid  = ($urandom_range(0, 2) == 0);
      wr_idx    = IW'($urandom_range(0, 3));
      wr_field  = 3'($urandom_range(0, 7));
      wr_data   = (wr_field == 3'd4) ? CW'($urandom_range(0, 4095))
                                     : CW'($urandom_range(0, 1050));
      commit    = ($urandom_range(0, 19) == 0);
      rst       = ($urandom_range(0, 599) != 0);
      step();
    end
    rst = 1'b1; wr_valid = 1'b0; commit = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
